// File: rtl/ttl_pkg.sv
// Shared types for the 74123-style one-shot: channel state and default width.
package ttl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } os_state_e;

    localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/ttl_74123_channel.sv
// One clocked one-shot channel. Define TTL_74123_RETRIGGER_EN to make a
// trigger during a pulse reload the counter (retriggerable behaviour).
module ttl_74123_channel
    import ttl_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int PULSE_CYCLES = 100
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic a_bar_i,
    input  logic b_i,
    input  logic clear_bar_i,
    output logic q_o
);

    localparam bit ARMED = (PULSE_CYCLES > 0);
    localparam logic [WIDTH-1:0] LOAD =
        ARMED ? WIDTH'(PULSE_CYCLES - 1) : '0;

`ifdef TTL_74123_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    os_state_e        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             en_prev_q, en_prev_d;
    logic             en;
    logic             trig;

    assign en   = ~a_bar_i & b_i & clear_bar_i;
    assign trig = en & ~en_prev_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        en_prev_d = en;
        if (!clear_bar_i) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trig && ARMED) begin
                        state_d = PULSE;
                        count_d = LOAD;
                    end
                end
                PULSE: begin
                    if (trig && RETRIG) begin
                        count_d = LOAD;
                    end else if (count_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // en_prev resets high so a level already enabled at release is not an edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            count_q   <= '0;
            en_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            en_prev_q <= en_prev_d;
        end
    end

    assign q_o = (state_q == PULSE);

endmodule

// File: rtl/ttl_74123.sv
// BLOCKS-wide clocked 74123 one-shot. Define TTL_74123_RETRIGGER_EN for the
// retriggerable variant; DELAY_RISE/DELAY_FALL only shape simulated outputs.
module ttl_74123
    import ttl_pkg::*;
#(
    parameter int BLOCKS       = 2,
    parameter int WIDTH        = DEF_WIDTH,
    parameter int PULSE_CYCLES = 100,
    parameter int DELAY_RISE   = 0,
    parameter int DELAY_FALL   = 0
) (
    input  logic              Clk,
    input  logic              Reset_bar,
    input  logic [BLOCKS-1:0] A_bar,
    input  logic [BLOCKS-1:0] B,
    input  logic [BLOCKS-1:0] Clear_bar,
    output logic [BLOCKS-1:0] Q,
    output logic [BLOCKS-1:0] Q_bar
);

    logic [BLOCKS-1:0] q_raw;

    for (genvar i = 0; i < BLOCKS; i++) begin : g_ch
        ttl_74123_channel #(
            .WIDTH        (WIDTH),
            .PULSE_CYCLES (PULSE_CYCLES)
        ) u_ch (
            .clk_i       (Clk),
            .rst_ni      (Reset_bar),
            .a_bar_i     (A_bar[i]),
            .b_i         (B[i]),
            .clear_bar_i (Clear_bar[i]),
            .q_o         (q_raw[i])
        );
    end

    if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_nodly
        assign Q = q_raw;
    end else begin : g_dly
        assign #(DELAY_RISE, DELAY_FALL) Q = q_raw;
    end

    // Derived from the final Q so the pair never disagrees, even with delays
    assign Q_bar = ~Q;

endmodule

// File: tb/tb_ttl_74123.sv
// Self-checking bench for ttl_74123: directed table, corner sequences, random.
module tb_ttl_74123;

    localparam int PC = 10;
    localparam int NB = 2;
`ifdef TTL_74123_RETRIGGER_EN
    localparam bit RT = 1'b1;
`else
    localparam bit RT = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset_bar;
    logic [NB-1:0] A_bar, B, Clear_bar, Q, Q_bar;
    logic [0:0]    a0, b0, c0, q0, qb0;

    ttl_74123 #(.BLOCKS(NB), .WIDTH(16), .PULSE_CYCLES(PC)) dut (
        .Clk(Clk), .Reset_bar(Reset_bar), .A_bar(A_bar), .B(B),
        .Clear_bar(Clear_bar), .Q(Q), .Q_bar(Q_bar)
    );

    ttl_74123 #(.BLOCKS(1), .WIDTH(16), .PULSE_CYCLES(0)) dut0 (
        .Clk(Clk), .Reset_bar(Reset_bar), .A_bar(a0), .B(b0),
        .Clear_bar(c0), .Q(q0), .Q_bar(qb0)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Model: remaining high cycles per channel, plus last sampled enable
    int rem [NB];
    bit pen [NB];
    int rem0;
    bit pen0;

    typedef struct {
        logic a;
        logic exp_q0;
    } vec_t;
    vec_t tbl [17];

    task automatic chk(string nm, logic [NB-1:0] act, logic [NB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NB-1:0] mq();
        logic [NB-1:0] r;
        for (int i = 0; i < NB; i++) r[i] = (rem[i] > 0);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            rem[i] = 0;
            pen[i] = 1'b1;
        end
        rem0 = 0;
        pen0 = 1'b1;
    endtask

    function automatic void step_one(input bit a, input bit b, input bit c,
                                     input int plen, inout int r, inout bit p);
        bit en, trig;
        en   = !a && b && c;
        trig = en && !p;
        p    = en;
        if (!c) r = 0;
        else if (trig && plen > 0 && (r == 0 || RT)) r = plen;
        else if (r > 0) r = r - 1;
    endfunction

    task automatic tick();
        @(posedge Clk);
        if (!Reset_bar) model_reset();
        else begin
            for (int i = 0; i < NB; i++)
                step_one(A_bar[i], B[i], Clear_bar[i], PC, rem[i], pen[i]);
            step_one(a0[0], b0[0], c0[0], 0, rem0, pen0);
        end
        #1;
        chk("model_q", Q, mq());
        chk("qbar_inv", Q_bar, ~mq());
        chk("pc0_model", {1'b0, q0}, {1'b0, rem0 > 0});
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        Reset_bar = 1'b0;
        model_reset();
        #1;
        chk("rst_q", Q, '0);
        chk("rst_qbar", Q_bar, '1);
        ticks(2);
        Reset_bar = 1'b1;
    endtask

    initial begin
        A_bar = '1; B = '1; Clear_bar = '1;
        a0 = 1'b1; b0 = 1'b1; c0 = 1'b1;
        Reset_bar = 1'b1;
        model_reset();
        #2;
        do_reset();

        // Entry k is applied before edge k; trigger edge is k=5
        for (int k = 0; k < 17; k++) begin
            tbl[k].a      = (k >= 5) ? 1'b0 : 1'b1;
            tbl[k].exp_q0 = (k >= 5 && k <= 14) ? 1'b1 : 1'b0;
        end
        for (int k = 1; k < 17; k++) begin
            A_bar[0] = tbl[k].a;
            tick();
            chk($sformatf("tbl_c%0d", k), Q, {1'b0, tbl[k].exp_q0});
        end

        // Second falling edge five cycles into the pulse
        A_bar[0] = 1'b1;
        ticks(2);
        for (int j = 0; j < 16; j++) begin
            A_bar[0] = (j == 3 || j == 4) ? 1'b1 : 1'b0;
            tick();
            chk($sformatf("retrig_j%0d", j), {1'b0, Q[0]},
                {1'b0, (j <= 9) ? 1'b1 : (j <= 14) ? RT : 1'b0});
        end

        // Clear three cycles into a pulse
        A_bar[0] = 1'b1;
        ticks(2);
        A_bar[0] = 1'b0;
        tick();
        chk("clr_start", Q, 2'b01);
        ticks(2);
        Clear_bar[0] = 1'b0;
        tick();
        chk("clr_drop", Q, 2'b00);
        tick();
        chk("clr_hold", Q, 2'b00);

        // Clear release is itself a trigger
        Clear_bar[0] = 1'b1;
        for (int j = 0; j < 11; j++) begin
            tick();
            chk($sformatf("clr_rel_j%0d", j), Q, {1'b0, j < 10});
        end

        // Enable already true across reset release: no pulse
        A_bar = '0; B = '1; Clear_bar = '1;
        a0 = 1'b0;
        do_reset();
        for (int j = 0; j < 12; j++) begin
            tick();
            chk($sformatf("rst_lvl_j%0d", j), Q, 2'b00);
        end

        // Async reset mid-pulse, no edge involved
        A_bar = '1;
        tick();
        A_bar = '0;
        tick();
        chk("arst_pre", Q, 2'b11);
        tick();
        #2;
        Reset_bar = 1'b0;
        model_reset();
        #1;
        chk("arst_q", Q, 2'b00);
        chk("arst_qbar", Q_bar, 2'b11);
        tick();
        Reset_bar = 1'b1;
        A_bar = '1;

        // Zero-length configuration ignores a valid trigger
        a0 = 1'b1;
        tick();
        a0 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("pc0_q", {1'b0, q0}, 2'b00);
            chk("pc0_qbar", {1'b0, qb0}, 2'b01);
        end

        // Randomised run against the model
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(3) == 0) A_bar[i] = ~A_bar[i];
                if ($urandom_range(7) == 0) B[i] = ~B[i];
                Clear_bar[i] = ($urandom_range(15) != 0);
            end
            a0 = 1'($urandom_range(1));
            b0 = 1'($urandom_range(1));
            c0 = 1'($urandom_range(1));
            if ($urandom_range(99) == 0) begin
                #2;
                Reset_bar = 1'b0;
                model_reset();
                #1;
                chk("rnd_arst", Q, 2'b00);
                tick();
                Reset_bar = 1'b1;
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
